// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (I) and data
//   (D, ldm/stm) requesters. One transaction at a time: IDLE picks an owner,
//   ISSUE strobes the memory, WAIT counts out the read latency, DONE raises a
//   registered done pulse (visible the cycle after DONE, while already IDLE).
//   D wins over I. Write latency req->done is 3 cycles; read is MEM_LAT+3.
//
//   Optional build macro MEM_ARB_FAIR_EN: after MAX_STREAK consecutive D grants
//   made while I was waiting, the next grant goes to I.
//
// Ports
//   clk, rst                     clock, async active-high reset
//   i_req/i_addr                 fetch request (held until i_done)
//   i_done/i_rdata/i_stall       fetch done pulse, word, stall = i_req & ~i_done
//   d_req/d_we/d_addr/d_wdata    data request (held until d_done)
//   d_done/d_rdata/d_stall       data done pulse, load word, stall = d_req & ~d_done
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe and request fields
//   mem_rdata                    memory read data, valid MEM_LAT cycles after mem_en
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || MAX_STREAK < 1) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT must be 1..15, MAX_STREAK >= 1");
  end

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_own_d, w_own_d_nxt;   // 1: D owns the transaction
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_i_done, r_d_done;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;
  logic              w_grant, w_grant_d, w_force_i, w_capture;

  assign w_grant   = (r_state == S_IDLE) && (i_req || d_req);
  // w_force_i can only be set while i_req=1, so I is always there to take it
  assign w_grant_d = d_req && !w_force_i;

`ifdef MEM_ARB_FAIR_EN
  localparam int STREAK_W = ($clog2(MAX_STREAK + 1) > 3) ? $clog2(MAX_STREAK + 1) : 3;
  logic [STREAK_W-1:0] r_streak;

  assign w_force_i = i_req && (r_streak == STREAK_W'(MAX_STREAK));

  // Only D grants that actually made I wait count toward the streak
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (w_grant) begin
      if (!w_grant_d)                    r_streak <= '0;
      else if (i_req && r_streak != '1) r_streak <= r_streak + STREAK_W'(1);
    end
  end
`else
  assign w_force_i = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_own_d_nxt = r_own_d;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_own_d_nxt = w_grant_d;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_own_d && d_we) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_own_d   <= 1'b0;
      r_cnt     <= '0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_own_d  <= w_own_d_nxt;
      r_cnt    <= w_cnt_nxt;
      r_i_done <= (r_state == S_DONE) && !r_own_d;
      r_d_done <= (r_state == S_DONE) &&  r_own_d;
      if (w_capture) begin
        if (r_own_d) r_d_rdata <= mem_rdata;
        else         r_i_rdata <= mem_rdata;
      end
    end
  end

  // Memory side is driven only in ISSUE so the bus stays quiet otherwise
  assign mem_en    = (r_state == S_ISSUE);
  assign mem_we    = mem_en && r_own_d && d_we;
  assign mem_addr  = !mem_en ? '0 : (r_own_d ? d_addr : i_addr);
  assign mem_wdata = (mem_en && r_own_d) ? d_wdata : '0;

  assign i_done  = r_i_done;
  assign d_done  = r_d_done;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign i_stall = i_req && !r_i_done;
  assign d_stall = d_req && !r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, LAT = 2, MAXS = 4;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic i_done, i_stall, d_done, d_stall, mem_en, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_chk = 0, n_pass = 0, cyc = 0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
  endtask

  // Environment memory (written by the DUT) and model memory (written by the model)
  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] mdl_mem [256];
  int rsp_due = -1;
  logic [DW-1:0] rsp_val = '0;

  // Transaction-level model: one transaction at a time, fixed latencies
  bit act = 0, t_d = 0, t_we = 0;
  int t_g = 0, t_lat = 0, free_c = 0, streak = 0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wd = '0, t_rd = '0, x_i_rd = '0, x_d_rd = '0;

  // Requester control
  bit i_busy = 0, d_busy = 0, rnd_en = 0, d_hold = 0;
  bit kick_i = 0, kick_d = 0, kick_d_we = 0;
  logic [AW-1:0] kick_i_addr = '0, kick_d_addr = '0;
  logic [DW-1:0] kick_d_wd = '0;

  // Observations for directed checks
  int obs_i_n = 0, obs_d_n = 0, last_i_done = -1, last_d_done = -1;
  int en_q[$];
  bit dq[$];
  logic [DW-1:0] i_rd_done = '0, d_rd_done = '0;

  function automatic int idx(logic [AW-1:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [7:0] w;
    w = 8'($urandom);
    return {22'd0, w, 2'b00};
  endfunction

  task automatic check_cycle();
    bit e_en, e_done, e_id, e_dd;
    e_en   = act && (cyc == t_g + 1);
    e_done = act && (cyc == t_g + t_lat);
    e_id   = e_done && !t_d;
    e_dd   = e_done &&  t_d;
    // read data becomes visible one cycle before the done pulse
    if (act && !t_we && cyc == t_g + LAT + 2) begin
      if (t_d) x_d_rd = t_rd; else x_i_rd = t_rd;
    end
    chk("mem_en", mem_en, e_en);
    if (e_en) begin
      chk("mem_we", mem_we, t_we);
      chk("mem_addr", mem_addr, t_addr);
      if (t_we) chk("mem_wdata", mem_wdata, t_wd);
    end
    chk("i_done", i_done, e_id);
    chk("d_done", d_done, e_dd);
    chk("i_rdata", i_rdata, x_i_rd);
    chk("d_rdata", d_rdata, x_d_rd);
    chk("i_stall", i_stall, i_req & ~e_id);
    chk("d_stall", d_stall, d_req & ~e_dd);
    if (i_done) begin obs_i_n++; last_i_done = cyc; i_rd_done = i_rdata; dq.push_back(1'b0); end
    if (d_done) begin obs_d_n++; last_d_done = cyc; d_rd_done = d_rdata; dq.push_back(1'b1); end
    if (mem_en) begin
      en_q.push_back(cyc);
      if (mem_we) env_mem[idx(mem_addr)] = mem_wdata;
      else begin rsp_due = cyc + LAT; rsp_val = env_mem[idx(mem_addr)]; end
    end
  endtask

  task automatic drive_reqs();
    bit i_end, d_end;
    i_end = act && !t_d && (cyc == t_g + t_lat);
    d_end = act &&  t_d && (cyc == t_g + t_lat);
    if (i_busy) begin
      if (i_end) begin i_busy = 0; i_req = 0; end
      else if (rnd_en && i_req && act && !t_d && cyc > t_g && $urandom_range(0, 19) == 0) i_req = 0;
    end
    if (!i_busy) begin
      if (kick_i) begin kick_i = 0; i_busy = 1; i_req = 1; i_addr = kick_i_addr; end
      else if (rnd_en && $urandom_range(0, 3) == 0) begin i_busy = 1; i_req = 1; i_addr = rnd_addr(); end
    end
    if (d_busy) begin
      if (d_end) begin
        if (d_hold) begin d_we = 1; d_addr = rnd_addr(); d_wdata = $urandom; end
        else begin d_busy = 0; d_req = 0; end
      end else if (rnd_en && d_req && act && t_d && cyc > t_g && $urandom_range(0, 19) == 0) d_req = 0;
    end
    if (!d_busy) begin
      if (kick_d) begin
        kick_d = 0; d_busy = 1; d_req = 1; d_we = kick_d_we; d_addr = kick_d_addr; d_wdata = kick_d_wd;
      end else if (rnd_en && $urandom_range(0, 3) == 0) begin
        d_busy = 1; d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = rnd_addr(); d_wdata = $urandom;
      end
    end
  endtask

  task automatic decide();
    if (cyc != free_c) return;
    if (d_req && !(FAIR && streak == MAXS && i_req)) begin
      t_d = 1; t_we = d_we; t_addr = d_addr; t_wd = d_wdata;
      if (i_req && streak < 7) streak++;
    end else if (i_req) begin
      t_d = 0; t_we = 0; t_addr = i_addr; t_wd = '0; streak = 0;
    end else begin
      act = 0; free_c = cyc + 1;
      return;
    end
    act = 1; t_g = cyc; t_lat = t_we ? 3 : LAT + 3;
    if (t_we) mdl_mem[idx(t_addr)] = t_wd;
    else      t_rd = mdl_mem[idx(t_addr)];
    free_c = cyc + t_lat;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_cycle();
    drive_reqs();
    decide();
    mem_rdata = (cyc == rsp_due) ? rsp_val : $urandom;
  endtask

  task automatic clr_obs();
    obs_i_n = 0; obs_d_n = 0; last_i_done = -1; last_d_done = -1;
    en_q.delete(); dq.delete();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_en"}, mem_en, 0);     chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0); chk({tag, "_wd"}, mem_wdata, 0);
    chk({tag, "_idone"}, i_done, 0);  chk({tag, "_ddone"}, d_done, 0);
    chk({tag, "_ird"}, i_rdata, 0);   chk({tag, "_drd"}, d_rdata, 0);
    chk({tag, "_istall"}, i_stall, 0); chk({tag, "_dstall"}, d_stall, 0);
  endtask

  task automatic rst_release();
    @(negedge clk);
    cyc++;
    rst = 0; i_req = 0; d_req = 0;
    act = 0; streak = 0; x_i_rd = '0; x_d_rd = '0; rsp_due = -1;
    i_busy = 0; d_busy = 0; kick_i = 0; kick_d = 0; d_hold = 0; rnd_en = 0;
    free_c = cyc + 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, n;
    for (int a = 0; a < 256; a++) begin
      env_mem[a] = DW'(a * 32'h01010101);
      mdl_mem[a] = env_mem[a];
    end
    // Reset state
    @(negedge clk);
    chk_zero("rst");
    rst_release();

    // I read of 0x40
    env_mem[16] = 32'hDEADBEEF; mdl_mem[16] = 32'hDEADBEEF;
    clr_obs(); kick_i = 1; kick_i_addr = 32'h40;
    step(); g0 = cyc;
    repeat (8) step();
    chk("i_rd_lat", last_i_done - g0, LAT + 3);
    chk("i_rd_en", (en_q.size() > 0) ? en_q[0] - g0 : -1, 1);
    chk("i_rd_val", i_rd_done, 32'hDEADBEEF);

    // D read of 0x80 loads d_rdata
    env_mem[32] = 32'h12345678; mdl_mem[32] = 32'h12345678;
    clr_obs(); kick_d = 1; kick_d_we = 0; kick_d_addr = 32'h80; kick_d_wd = '0;
    step(); g0 = cyc;
    repeat (8) step();
    chk("d_rd_lat", last_d_done - g0, LAT + 3);
    chk("d_rd_val", d_rd_done, 32'h12345678);

    // D write 0x100 <- 0x55; d_rdata must hold the earlier load
    clr_obs(); kick_d = 1; kick_d_we = 1; kick_d_addr = 32'h100; kick_d_wd = 32'h55;
    step(); g0 = cyc;
    repeat (6) step();
    chk("d_wr_lat", last_d_done - g0, 3);
    chk("d_wr_en", (en_q.size() > 0) ? en_q[0] - g0 : -1, 1);
    chk("d_wr_keep", d_rdata, 32'h12345678);
    chk("d_wr_mem", env_mem[64], 32'h55);

    // I and D (read 0x100) together: D first, I issued right after d_done
    clr_obs();
    kick_i = 1; kick_i_addr = 32'h40;
    kick_d = 1; kick_d_we = 0; kick_d_addr = 32'h100; kick_d_wd = '0;
    step(); g0 = cyc;
    repeat (14) step();
    chk("both_d_first", last_d_done - g0, LAT + 3);
    chk("both_i_issue", (en_q.size() > 1) ? en_q[1] : -1, last_d_done + 1);
    chk("both_i_done", last_i_done, last_d_done + LAT + 3);
    chk("both_d_val", d_rd_done, 32'h55);

    // Random traffic
    rnd_en = 1;
    repeat (1500) step();
    rnd_en = 0;
    repeat (20) step();

    // Async reset in the middle of a read's WAIT
    clr_obs(); kick_i = 1; kick_i_addr = rnd_addr();
    n = 0;
    do begin step(); n++; end while (!(act && !t_d && cyc == t_g + 2) && n < 20);
    chk("wait_reach", n < 20, 1);
    #2; rst = 1; i_req = 0; d_req = 0;
    #1; chk_zero("rst_wait");
    repeat (3) begin
      @(negedge clk); cyc++;
      chk("rst_hold_idone", i_done, 0);
      chk("rst_hold_ddone", d_done, 0);
    end
    rst_release();
    repeat (LAT + 5) step();
    chk("rst_no_done", obs_i_n + obs_d_n, 0);

    // Continuous D writes with I waiting
    clr_obs(); d_hold = 1;
    kick_i = 1; kick_i_addr = 32'h40;
    kick_d = 1; kick_d_we = 1; kick_d_addr = 32'h200; kick_d_wd = 32'hA5;
    repeat (50) step();
`ifdef MEM_ARB_FAIR_EN
    chk("fair_n", dq.size() >= 5, 1);
    if (dq.size() >= 5) begin
      for (int k = 0; k < 4; k++) chk("fair_d", dq[k], 1);
      chk("fair_i", dq[4], 0);
    end
`else
    chk("starve_i", obs_i_n, 0);
    chk("starve_d", obs_d_n >= 10, 1);
`endif
    d_hold = 0;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
